// File: rtl/timer_pkg.sv
// timer_pkg: shared constants, FSM state type, 7-segment patterns and the
// double-dabble add-3 helper for the stopwatch BCD converter.
package timer_pkg;

  localparam int unsigned TIMER_WIDTH = 16;
  localparam int unsigned BCD_DIGITS  = 5;
  localparam int unsigned BCD_W       = 4 * BCD_DIGITS;
  localparam int unsigned CNT_W       = 5;
  localparam int unsigned SEG_W       = 7;
  localparam int unsigned SEG_BUS_W   = SEG_W * BCD_DIGITS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Active-low {g,f,e,d,c,b,a} patterns
  localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b0010000;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

  // Add 3 to every digit >= 5; digits below 5 pass unchanged, so applying
  // it to all digits each step gives the same result as the minimal form.
  function automatic logic [BCD_W-1:0] bcd_add3(input logic [BCD_W-1:0] v);
    logic [BCD_W-1:0] r;
    r = v;
    for (int i = 0; i < int'(BCD_DIGITS); i++) begin
      if (v[4*i +: 4] >= 4'd5) r[4*i +: 4] = v[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/timer_bcd_conv_if.sv
// timer_bcd_conv_if: request/result bundle between the timer side (master)
// and the BCD converter (slave).
//   bin_in     binary count to convert (master -> slave)
//   conv_start single-cycle conversion request (master -> slave)
//   busy       conversion in progress (slave -> master)
//   done       one-cycle result-updated pulse (slave -> master)
//   bcd_out    {d4..d0} result, held between conversions (slave -> master)
//   seg_out    five active-low 7-seg patterns, only with TIMER_BCD_SEG7_EN
interface timer_bcd_conv_if;
  import timer_pkg::*;

  logic [TIMER_WIDTH-1:0] bin_in;
  logic                   conv_start;
  logic                   busy;
  logic                   done;
  logic [BCD_W-1:0]       bcd_out;
`ifdef TIMER_BCD_SEG7_EN
  logic [SEG_BUS_W-1:0]   seg_out;

  modport master (output bin_in, conv_start, input busy, done, bcd_out, seg_out);
  modport slave  (input bin_in, conv_start, output busy, done, bcd_out, seg_out);
`else
  modport master (output bin_in, conv_start, input busy, done, bcd_out);
  modport slave  (input bin_in, conv_start, output busy, done, bcd_out);
`endif

endinterface

// File: rtl/bcd_to_seg7.sv
// bcd_to_seg7: one BCD digit to an active-low {g,f,e,d,c,b,a} pattern.
// Codes 10-15 blank the digit. Only built with TIMER_BCD_SEG7_EN.
//   digit_i  4-bit BCD digit
//   seg_o    7-bit active-low segment pattern (combinational)
`ifdef TIMER_BCD_SEG7_EN
module bcd_to_seg7
  import timer_pkg::*;
(
  input  logic [3:0]       digit_i,
  output logic [SEG_W-1:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (digit_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule
`endif

// File: rtl/timer_bcd_conv.sv
// timer_bcd_conv: iterative 16-bit binary to 5-digit BCD converter
// (double dabble, one bit per clock) behind a start/busy/done handshake.
// Optional macro TIMER_BCD_SEG7_EN adds five combinational 7-seg decoders.
//   clk     system clock, rising edge
//   reset   asynchronous active-high reset
//   bus_if  slave side of timer_bcd_conv_if (bin_in, conv_start, busy,
//           done, bcd_out, and seg_out when the display option is built)
module timer_bcd_conv
  import timer_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  timer_bcd_conv_if.slave  bus_if
);

  state_e                 state_q, state_d;
  logic [TIMER_WIDTH-1:0] shift_q, shift_d;
  logic [BCD_W-1:0]       scratch_q, scratch_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [BCD_W-1:0]       bcd_q, bcd_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [BCD_W-1:0]       adj;
  logic                   accept;
  logic                   last_shift;

  assign accept     = ((state_q == IDLE) || (state_q == DONE)) && bus_if.conv_start;
  assign last_shift = (cnt_q == CNT_W'(TIMER_WIDTH - 1));

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: state_d = bus_if.conv_start ? SHIFT : IDLE;
      SHIFT:      if (last_shift) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  // Output and datapath next values
  always_comb begin
    busy_d    = (state_d == SHIFT);
    done_d    = (state_d == DONE);
    shift_d   = shift_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    bcd_d     = bcd_q;
    adj       = bcd_add3(scratch_q);
    if (accept) begin
      shift_d   = bus_if.bin_in;
      scratch_d = '0;
      cnt_d     = '0;
    end else if (state_q == SHIFT) begin
      {scratch_d, shift_d} = {adj, shift_q} << 1;
      cnt_d                = cnt_q + CNT_W'(1);
      // bcd_out updates only on the edge that enters DONE
      if (last_shift) bcd_d = scratch_d;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      bcd_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      shift_q   <= shift_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      bcd_q     <= bcd_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus_if.busy    = busy_q;
  assign bus_if.done    = done_q;
  assign bus_if.bcd_out = bcd_q;

`ifdef TIMER_BCD_SEG7_EN
  logic [SEG_BUS_W-1:0] seg_c;

  // Decode straight from the held result: no extra latency
  for (genvar g = 0; g < int'(BCD_DIGITS); g++) begin : g_seg
    bcd_to_seg7 u_seg (
      .digit_i (bcd_q[4*g +: 4]),
      .seg_o   (seg_c[SEG_W*g +: SEG_W])
    );
  end

  assign bus_if.seg_out = seg_c;
`endif

endmodule

// File: tb/tb_timer_bcd_conv.sv
// tb_timer_bcd_conv: self-checking bench for timer_bcd_conv with directed
// and randomized conversions against an arithmetic decimal model.
module tb_timer_bcd_conv;

  logic clk = 1'b0;
  logic reset;

  timer_bcd_conv_if bus_if ();

  timer_bcd_conv dut (
    .clk    (clk),
    .reset  (reset),
    .bus_if (bus_if)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [19:0] last_exp = 20'h0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Decimal digits by repeated division
  function automatic logic [19:0] model_bcd(input int unsigned v);
    logic [19:0] r;
    int unsigned x;
    r = '0;
    x = v;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

`ifdef TIMER_BCD_SEG7_EN
  function automatic logic [34:0] model_seg(input logic [19:0] b);
    logic [6:0] pat [10];
    logic [34:0] r;
    pat = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    r = '0;
    for (int i = 0; i < 5; i++) r[7*i +: 7] = pat[int'(b[4*i +: 4])];
    return r;
  endfunction
`endif

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept v, optionally change bin_in after accept and/or pulse a stray
  // conv_start mid-shift; returns in the DONE cycle after checking.
  task automatic run_conv(input logic [15:0] v, input bit scramble, input bit stray);
    int unsigned lat;
    int unsigned busy_n;
    bit hold_ok;
    lat = 0;
    busy_n = 0;
    hold_ok = 1'b1;
    bus_if.bin_in = v;
    bus_if.conv_start = 1'b1;
    step();
    bus_if.conv_start = 1'b0;
    if (scramble) bus_if.bin_in = 16'd9999;
    while (bus_if.done !== 1'b1 && lat < 40) begin
      if (bus_if.busy === 1'b1) busy_n++;
      if (bus_if.bcd_out !== last_exp) hold_ok = 1'b0;
      if (stray && lat == 5) begin
        bus_if.conv_start = 1'b1;
        bus_if.bin_in = 16'd7;
      end else if (stray && lat == 6) begin
        bus_if.conv_start = 1'b0;
      end
      step();
      lat++;
    end
    last_exp = model_bcd(int'(v));
    check("latency", 64'(lat), 64'd16);
    check("busy_cycles", 64'(busy_n), 64'd16);
    check("busy_at_done", 64'(bus_if.busy), 64'd0);
    check("hold_during_shift", 64'(hold_ok), 64'd1);
    check("bcd_out", 64'(bus_if.bcd_out), 64'(last_exp));
`ifdef TIMER_BCD_SEG7_EN
    check("seg_out", 64'(bus_if.seg_out), 64'(model_seg(last_exp)));
`endif
  endtask

  // Leave DONE without a new request: pulse must end, result must hold
  task automatic leave_done();
    step();
    check("done_one_cycle", 64'(bus_if.done), 64'd0);
    check("bcd_hold_idle", 64'(bus_if.bcd_out), 64'(last_exp));
  endtask

  initial begin
    int unsigned gap;
    bit quiet;
    logic [15:0] v;

    reset = 1'b1;
    bus_if.bin_in = '0;
    bus_if.conv_start = 1'b0;
    repeat (3) step();
    check("rst_busy", 64'(bus_if.busy), 64'd0);
    check("rst_done", 64'(bus_if.done), 64'd0);
    check("rst_bcd", 64'(bus_if.bcd_out), 64'd0);
    reset = 1'b0;
    step();
    check("idle_busy", 64'(bus_if.busy), 64'd0);
    check("idle_bcd", 64'(bus_if.bcd_out), 64'd0);
`ifdef TIMER_BCD_SEG7_EN
    check("rst_seg_d0", 64'(bus_if.seg_out[6:0]), 64'h40);
    check("rst_seg_all", 64'(bus_if.seg_out), 64'(model_seg(20'h0)));
`endif

    // Directed values
    run_conv(16'd1234, 1'b0, 1'b0);
    check("bcd_1234", 64'(bus_if.bcd_out), 64'h01234);
    leave_done();
    run_conv(16'hFFFF, 1'b1, 1'b0);
    check("bcd_max", 64'(bus_if.bcd_out), 64'h65535);
    leave_done();
    run_conv(16'd0, 1'b1, 1'b0);
    check("bcd_zero", 64'(bus_if.bcd_out), 64'h00000);
    leave_done();

    // Stray start during SHIFT is ignored and not queued
    run_conv(16'd42, 1'b0, 1'b1);
    check("bcd_42", 64'(bus_if.bcd_out), 64'h00042);
    quiet = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus_if.done !== 1'b0 || bus_if.busy !== 1'b0) quiet = 1'b0;
    end
    check("no_queued_start", 64'(quiet), 64'd1);

    // Back-to-back: request in the DONE cycle
    run_conv(16'd42, 1'b0, 1'b0);
    bus_if.bin_in = 16'd7;
    bus_if.conv_start = 1'b1;
    step();
    bus_if.conv_start = 1'b0;
    gap = 1;
    while (bus_if.done !== 1'b1 && gap < 40) begin
      step();
      gap++;
    end
    last_exp = 20'h00007;
    check("b2b_interval", 64'(gap), 64'd17);
    check("b2b_bcd", 64'(bus_if.bcd_out), 64'h00007);
    leave_done();

    // Reset in the middle of a conversion
    bus_if.bin_in = 16'd500;
    bus_if.conv_start = 1'b1;
    step();
    bus_if.conv_start = 1'b0;
    repeat (8) step();
    reset = 1'b1;
    #1;
    check("abort_busy", 64'(bus_if.busy), 64'd0);
    check("abort_done", 64'(bus_if.done), 64'd0);
    check("abort_bcd", 64'(bus_if.bcd_out), 64'd0);
    last_exp = 20'h0;
    step();
    reset = 1'b0;
    quiet = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus_if.done !== 1'b0) quiet = 1'b0;
    end
    check("abort_no_done", 64'(quiet), 64'd1);
    run_conv(16'd500, 1'b0, 1'b0);
    check("bcd_500", 64'(bus_if.bcd_out), 64'h00500);
    leave_done();

`ifdef TIMER_BCD_SEG7_EN
    run_conv(16'd8080, 1'b0, 1'b0);
    check("seg_8080", 64'(bus_if.seg_out),
          64'({7'b1000000, 7'b0000000, 7'b1000000, 7'b0000000, 7'b1000000}));
    leave_done();
`endif

    // Randomized conversions
    for (int n = 0; n < 24; n++) begin
      v = 16'($urandom);
      if ($urandom_range(0, 3) == 0) v = 16'($urandom_range(0, 99));
      repeat ($urandom_range(0, 3)) step();
      run_conv(v, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      leave_done();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/timer_bcd_conv.md
# timer_bcd_conv

Sequential binary-to-BCD converter that consumes the 16-bit elapsed-time count produced by the stopwatch timer and presents it as five decimal digits for the board display. It runs iterative shift-add-3 (double dabble), one bit per clock, behind a start/busy/done handshake. Results are held stable between conversions. With the display option compiled in, it also drives five active-low 7-segment digit patterns.

## Interface
- `WIDTH`, 16, binary input width; fixed at 16 for this block.
- `DIGITS`, 5, BCD digit count; ceil(WIDTH·log10(2)) = 5.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `bin_in`  in  16  binary value to convert; the timer's count output connects here.
- `conv_start`  in  1  single-cycle request; sampled only in IDLE or DONE.
- `busy`  out  1  high while shifting.
- `done`  out  1  one-cycle pulse; `bcd_out` has just been updated.
- `bcd_out`  out  20  {d4,d3,d2,d1,d0}; d0 is the units digit, 4 bits each.
- `seg_out`  out  35  only with `TIMER_BCD_SEG7_EN`; five 7-bit {g,f,e,d,c,b,a} patterns, active-low, digit 0 in bits [6:0].

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE: when `conv_start`=1, capture `bin_in` into the shift register, clear the BCD scratch and bit counter (5 bits), and go to SHIFT. Otherwise stay in IDLE.
- SHIFT, each cycle:
  - For every scratch digit ≥5, add 3.
  - Shift {scratch, shift_reg} left by 1.
  - Increment the counter.
  - On the 16th shift, load `bcd_out` with the final scratch value and go to DONE.
- DONE: `done`=1 for exactly one cycle. If `conv_start`=1, handle it as in IDLE (back-to-back). Otherwise go to IDLE.
- `conv_start` in SHIFT is ignored; it is not queued.
- `bin_in` is sampled only at accept. Later changes do not affect the conversion in flight.
- Width rule:
  - The add-3 applies only to digits that can hold ≥5 at that step. Applying it to all five every cycle is also allowed, because the result is identical.
  - Every digit of `bcd_out` is always 0–9. The maximum is 65535 → 6,5,5,3,5.
- `bcd_out` changes only on the DONE-entry edge or on reset. Between those it holds.
- Reset mid-conversion aborts: state goes to IDLE, no `done` pulse, `bcd_out` is cleared to 0.

## Timing
- Accept on edge k. `busy`=1 in the cycles after edges k … k+15 (16 cycles).
- Edge k+16: `bcd_out` is valid, `done`=1 and `busy`=0.
- Latency from accept to `done` is 16 cycles. The minimum interval between back-to-back results is 17 cycles.
- `busy` and `done` are never high together.
- Reset values: `busy`=0, `done`=0, `bcd_out`=0, state=IDLE, and, when enabled, `seg_out`={5{7'b1000000}} (all digits show "0").

## Configuration
- `TIMER_BCD_SEG7_EN` defined:
  - The `seg_out` port exists.
  - Each digit of `bcd_out` is decoded combinationally, so there is no added latency.
  - Digit codes 10–15 cannot occur; decode them to all segments off (7'b1111111).
- Not defined:
  - The `seg_out` port and decoders are absent.
  - The block is BCD only, for designs whose display driver does its own decoding.

## Structure
- Shared package `timer_pkg` holds:
  - `TIMER_WIDTH`=16 and `BCD_DIGITS`=5;
  - the state enum (IDLE/SHIFT/DONE);
  - 7-segment pattern constants SEG_0…SEG_9 and SEG_BLANK.
- One sub-module, `bcd_to_seg7`: a 4-bit digit in, a 7-bit active-low pattern out. It is instantiated five times, and only under the macro.

## Test plan
- Reset then idle: `busy`=0, `done`=0, `bcd_out`=0. With the macro, `seg_out` digit 0 = 7'b1000000.
- `bin_in`=16'd1234, pulse `conv_start` → `done` exactly 16 cycles after accept; `bcd_out`=20'h01234; `busy` high for 16 cycles.
- `bin_in`=16'hFFFF → `bcd_out`=20'h65535. `bin_in`=0 → 20'h00000. Both are checked with `bin_in` changed to 16'd9999 right after accept, and the result must be unaffected.
- Accept 16'd42, then pulse `conv_start` with `bin_in`=16'd7 during SHIFT → result 20'h00042 and only one `done`. Then `conv_start` during DONE with `bin_in`=16'd7 → second `done` 17 cycles after the first, `bcd_out`=20'h00007.
- Accept 16'd500, assert `reset` at shift 8 → outputs cleared at once and no `done`. Then convert 16'd500 → 20'h00500.
- With the macro, convert 16'd8080 → `seg_out` digits {d4..d0} = {1000000, 0000000, 1000000, 0000000, 1000000}.
